wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter between the execute-side producers and the register file's single write port. Accepts results from the single-cycle ALU (no backpressure) and the multi-cycle load/store unit (valid/ready), queues LSU results in a small FIFO, and drives one registered write per cycle onto the register file's `wr_en`/`wr_addr`/`wr_data`. Also reports read-after-write hazards against the two register-file read addresses so the issue stage can stall.

## Interface
- `DATA_W`, 33: result/register width; matches register file data width
- `ADDR_W`, 5: register address width
- `DEPTH`, 4: LSU FIFO entries; power of two, ≥ 2
- `STARVE_LIM`, 8: consecutive cycles a non-empty FIFO head may lose to the ALU before `starve` asserts

- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `alu_valid` input 1: ALU result present this cycle; always accepted
- `alu_addr` input ADDR_W: ALU destination register
- `alu_data` input DATA_W: ALU result
- `lsu_valid` input 1: LSU result offered
- `lsu_ready` output 1: arbiter can accept an LSU result
- `lsu_addr` input ADDR_W: LSU destination register
- `lsu_data` input DATA_W: LSU result
- `rd0_addr`, `rd1_addr` input ADDR_W: current register-file read addresses
- `rd0_hazard`, `rd1_hazard` output 1: a pending write targets the matching read address
- `starve` output 1: issue stage must withhold ALU issue next cycle
- `wr_en` output 1: register-file write enable (registered)
- `wr_addr` output ADDR_W: register-file write address (registered)
- `wr_data` output DATA_W: register-file write data (registered)

## Operation
- Output stage selection each cycle, priority order: (1) `alu_valid` → load ALU result; (2) FIFO non-empty → pop head and load it; (3) FIFO empty and LSU handshake → bypass the LSU result directly into the output stage without storing it; (4) otherwise `wr_en` ← 0.
- LSU handshake: transfer when `lsu_valid && lsu_ready`. `lsu_ready` = `!rst && count < DEPTH`, based on the registered count. A full FIFO refuses a push even when a pop occurs in the same cycle.
- LSU push is stored in the FIFO when the ALU wins that cycle, or when the FIFO is already non-empty. LSU results leave the FIFO in FIFO order. The ALU may overtake queued LSU writes; the issue stage prevents same-register reordering using the hazard outputs.
- `rdN_hazard` is combinational and asserts when either of these targets `rdN_addr`: any valid FIFO entry, or the output stage while `wr_en` = 1.
- Starvation counter: increments each cycle the FIFO is non-empty and the ALU wins. It clears on any FIFO pop or when the FIFO is empty. It saturates at `STARVE_LIM`. `starve` = (counter == `STARVE_LIM`).
- Reset clears: `wr_en`, `wr_addr`, `wr_data`, FIFO pointers and count, the starvation counter, and `starve`, all to 0. A reset mid-operation discards queued results.

## Timing
- ALU: result on `wr_*` one cycle after `alu_valid`; register file commits at the following edge.
- LSU, bypass path: 1 cycle latency. LSU, queued path: at least 2 cycles.
- Pointer wrap-around: modulo `DEPTH`. Count width is clog2(`DEPTH`)+1.
- The block never drops a result and never writes twice for one handshake.

## Configuration
- `WB_ZERO_REG_EN` defined: results addressed to register 0 from either source are consumed, but are neither queued nor written. The LSU handshake still completes. `rdN_hazard` is forced to 0 when `rdN_addr` = 0.
- `WB_ZERO_REG_EN` undefined: register 0 is an ordinary destination.

## Structure
- Shared package `wb_pkg` holds:
  - `DATA_W` and `ADDR_W` defaults
  - `wb_entry_t` struct {addr, data}
- Sub-module `wb_fifo` contains the storage array, pointers, count, full/empty, and per-entry address-match vectors used for hazard detection.

## Test plan
- Reset released with idle inputs → `wr_en`=0, `lsu_ready`=1, hazards 0. Then `alu_valid` with addr 3, data 0x1_0000_00AA → next cycle `wr_en`=1, `wr_addr`=3, `wr_data`=0x1_0000_00AA.
- LSU result, addr 7, with FIFO empty and ALU idle → written the next cycle (bypass); FIFO count stays 0.
- ALU and LSU valid in the same cycle (ALU addr 1, LSU addr 2) → addr 1 written in cycle 1, addr 2 in cycle 2. While addr 2 is queued, `rd0_addr`=2 gives `rd0_hazard`=1.
- ALU held valid for 10 cycles with 4 LSU pushes → `lsu_ready` drops after 4. `starve` asserts once the head has lost 8 cycles in a row. When the ALU drops, the four entries drain in order.
- Assert `rst` with 3 queued entries → next cycle count=0, `wr_en`=0, and no queued write ever appears.
- With `WB_ZERO_REG_EN`: ALU write to addr 0 → `wr_en` stays 0. Without it → `wr_en`=1, `wr_addr`=0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and default widths for the writeback arbiter slice.
package wb_pkg;

   localparam int DATA_W = 33;
   localparam int ADDR_W = 5;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_FIFO = 2'd2,
      SEL_BYP  = 2'd3
   } wb_sel_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Producer/register-file bundle of the writeback arbiter; slave is the arbiter side.
interface wb_arbiter_if
   import wb_pkg::*;
#(
   parameter int DATA_W = wb_pkg::DATA_W,
   parameter int ADDR_W = wb_pkg::ADDR_W
);
   logic              alu_valid;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              lsu_valid;
   logic              lsu_ready;
   logic [ADDR_W-1:0] lsu_addr;
   logic [DATA_W-1:0] lsu_data;
   logic [ADDR_W-1:0] rd0_addr;
   logic [ADDR_W-1:0] rd1_addr;
   logic              rd0_hazard;
   logic              rd1_hazard;
   logic              starve;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport master (
      output alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
             rd0_addr, rd1_addr,
      input  lsu_ready, rd0_hazard, rd1_hazard, starve, wr_en, wr_addr, wr_data
   );

   modport slave (
      input  alu_valid, alu_addr, alu_data, lsu_valid, lsu_addr, lsu_data,
             rd0_addr, rd1_addr,
      output lsu_ready, rd0_hazard, rd1_hazard, starve, wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/wb_fifo.sv
// LSU result queue: storage, pointers, count and per-entry address matches for hazards.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  wb_entry_t              push_entry,
   input  logic                   pop,
   output wb_entry_t              head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   input  logic [ADDR_W-1:0]      rd0_addr,
   input  logic [ADDR_W-1:0]      rd1_addr,
   output logic [DEPTH-1:0]       match0,
   output logic [DEPTH-1:0]       match1
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t         mem_r [DEPTH];
   logic [DEPTH-1:0]  valid_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [CNT_W-1:0]  count_r;
   logic              full_s;
   logic              do_push_s;
   logic              do_pop_s;

   assign full_s    = (count_r == CNT_W'(DEPTH));
   assign empty     = (count_r == {CNT_W{1'b0}});
   assign do_push_s = push && !full_s;
   assign do_pop_s  = pop && !empty;
   assign head      = mem_r[rd_ptr_r];
   assign count     = count_r;

   // Entry storage; contents are qualified by valid_r so they need no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_entry;
      end
   end

   // Pointers, occupancy and per-entry valid bits; pointers wrap modulo DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         valid_r  <= {DEPTH{1'b0}};
      end else begin
         if (do_push_s) begin
            valid_r[wr_ptr_r] <= 1'b1;
            wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
         end
         if (do_pop_s) begin
            valid_r[rd_ptr_r] <= 1'b0;
            rd_ptr_r          <= rd_ptr_r + PTR_W'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Address match of every live entry against both read ports.
   always_comb begin
      match0 = {DEPTH{1'b0}};
      match1 = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         match0[i] = valid_r[i] && (mem_r[i].addr == rd0_addr);
         match1[i] = valid_r[i] && (mem_r[i].addr == rd1_addr);
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU and queued LSU results onto one registered register-file write port.
// Optional WB_ZERO_REG_EN: results to register 0 are consumed but never queued or written.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int DATA_W     = wb_pkg::DATA_W,
   parameter int ADDR_W     = wb_pkg::ADDR_W,
   parameter int DEPTH      = 4,
   parameter int STARVE_LIM = 8
) (
   input logic         clk,
   input logic         rst,
   wb_arbiter_if.slave bus
);
   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int SCNT_W = $clog2(STARVE_LIM + 1);

   logic [CNT_W-1:0]  count_s;
   logic              empty_s;
   wb_entry_t         head_s;
   wb_entry_t         push_entry_s;
   logic [DEPTH-1:0]  match0_s;
   logic [DEPTH-1:0]  match1_s;
   logic              lsu_fire_s;
   logic              alu_take_s;
   logic              lsu_keep_s;
   logic              rd0_ok_s;
   logic              rd1_ok_s;
   logic              push_s;
   logic              pop_s;
   wb_sel_e           sel_s;
   logic [SCNT_W-1:0] starve_cnt_r;
   logic [SCNT_W-1:0] starve_cnt_nxt_s;
   logic              starve_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;

   assign bus.lsu_ready = !rst && (count_s < CNT_W'(DEPTH));
   assign lsu_fire_s    = bus.lsu_valid && bus.lsu_ready;

`ifdef WB_ZERO_REG_EN
   assign alu_take_s = bus.alu_valid && (|bus.alu_addr);
   assign lsu_keep_s = lsu_fire_s && (|bus.lsu_addr);
   assign rd0_ok_s   = |bus.rd0_addr;
   assign rd1_ok_s   = |bus.rd1_addr;
`else
   assign alu_take_s = bus.alu_valid;
   assign lsu_keep_s = lsu_fire_s;
   assign rd0_ok_s   = 1'b1;
   assign rd1_ok_s   = 1'b1;
`endif

   assign push_entry_s.addr = bus.lsu_addr;
   assign push_entry_s.data = bus.lsu_data;
   // An LSU result is only queued if it cannot go straight to the output stage.
   assign push_s = lsu_keep_s && (alu_take_s || !empty_s);
   assign pop_s  = (sel_s == SEL_FIFO);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push_s),
      .push_entry (push_entry_s),
      .pop        (pop_s),
      .head       (head_s),
      .count      (count_s),
      .empty      (empty_s),
      .rd0_addr   (bus.rd0_addr),
      .rd1_addr   (bus.rd1_addr),
      .match0     (match0_s),
      .match1     (match1_s)
   );

   // Output-stage source selection: ALU, then FIFO head, then LSU bypass.
   always_comb begin
      sel_s = SEL_NONE;
      if (alu_take_s) begin
         sel_s = SEL_ALU;
      end else if (!empty_s) begin
         sel_s = SEL_FIFO;
      end else if (lsu_keep_s) begin
         sel_s = SEL_BYP;
      end else begin
         sel_s = SEL_NONE;
      end
   end

   // Next starvation count: grows while a queued head loses to the ALU, saturating.
   always_comb begin
      starve_cnt_nxt_s = starve_cnt_r;
      if (empty_s || pop_s) begin
         starve_cnt_nxt_s = {SCNT_W{1'b0}};
      end else if (alu_take_s) begin
         starve_cnt_nxt_s = (starve_cnt_r == SCNT_W'(STARVE_LIM)) ?
                            starve_cnt_r : starve_cnt_r + SCNT_W'(1);
      end else begin
         starve_cnt_nxt_s = starve_cnt_r;
      end
   end

   // Registered write port and starvation state.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en_r      <= 1'b0;
         wr_addr_r    <= {ADDR_W{1'b0}};
         wr_data_r    <= {DATA_W{1'b0}};
         starve_cnt_r <= {SCNT_W{1'b0}};
         starve_r     <= 1'b0;
      end else begin
         starve_cnt_r <= starve_cnt_nxt_s;
         starve_r     <= (starve_cnt_nxt_s == SCNT_W'(STARVE_LIM));
         case (sel_s)
            SEL_ALU: begin
               wr_en_r   <= 1'b1;
               wr_addr_r <= bus.alu_addr;
               wr_data_r <= bus.alu_data;
            end
            SEL_FIFO: begin
               wr_en_r   <= 1'b1;
               wr_addr_r <= head_s.addr;
               wr_data_r <= head_s.data;
            end
            SEL_BYP: begin
               wr_en_r   <= 1'b1;
               wr_addr_r <= bus.lsu_addr;
               wr_data_r <= bus.lsu_data;
            end
            default: begin
               wr_en_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.wr_en      = wr_en_r;
   assign bus.wr_addr    = wr_addr_r;
   assign bus.wr_data    = wr_data_r;
   assign bus.starve     = starve_r;
   assign bus.rd0_hazard = rd0_ok_s &&
                           ((|match0_s) || (wr_en_r && (wr_addr_r == bus.rd0_addr)));
   assign bus.rd1_hazard = rd1_ok_s &&
                           ((|match1_s) || (wr_en_r && (wr_addr_r == bus.rd1_addr)));
endmodule
